multicycle_controller: RTL and testbench

// Moore/Mealy FSM that sequences the multi-cycle variant of the MIPS datapath (shared memory, IR, A/B/ALUOut regs).

---
 rtl/mips_ctrl_pkg.sv | 72 +++++++
 rtl/mc_output_decode.sv | 76 +++++++
 rtl/multicycle_controller.sv | 97 +++++++++
 tb/tb_multicycle_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcodes, datapath select encodings and the packed control word.
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_BRANCH = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Instruction class captured in DECODE so later states never look at the bus again.
  typedef struct packed {
    logic is_sw;
    logic is_bne;
  } op_cls_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_LW)    || (op == OP_SW)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Pure combinational control-word decode from the current state, with the few
// Mealy terms (memory ready, illegal opcode) folded in.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t                state,
  input  logic                  mem_ready,
  input  logic [OPCODE_W-1:0]   operation,
  input  logic                  branch_ne_sel,
  output ctrl_t                 ctrl
);

  always_comb begin
    // NOTE: defaulting the whole word first keeps every path assigned, so no latches.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !is_legal_op(operation);
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = branch_ne_sel;
        ctrl.instr_done    = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// and drives the datapath enables through mc_output_decode.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] operation,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           BranchNe,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic [STW-1:0] state_o,
  output logic           instr_done,
  output logic           illegal_op
);

  state_t  state;
  op_cls_t op_cls;
  ctrl_t   ctrl;

  // Async reset forces S_RESET immediately, so every strobe drops without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RESET;
      op_cls <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_cls.is_sw  <= (operation == OP_SW);
          op_cls.is_bne <= (operation == OP_BNE);
          case (operation)
            OP_RTYPE:       state <= S_EXEC;
            OP_BEQ, OP_BNE: state <= S_BRANCH;
            OP_LW, OP_SW:   state <= S_MEMADR;
            OP_ADDI:        state <= S_ADDIEX;
            default:        state <= S_FETCH;
          endcase
        end
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_MEMADR: state <= op_cls.is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  mc_output_decode u_decode (
    .state         (state),
    .mem_ready     (mem_ready),
    .operation     (operation),
    .branch_ne_sel (op_cls.is_bne),
    .ctrl          (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNe    = ctrl.branch_ne;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign state_o     = STW'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors push
// expected state + control word; a negedge monitor pops and compares.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] operation;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;

  multicycle_controller #(.OPW(6), .STW(4)) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state_o(state_o), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Field order: {PCWrite,PCWriteCond,BranchNe,IorD}_{MemRead,MemWrite,IRWrite,MemtoReg}_
  // {RegDst,RegWrite,ALUSrcA}_ALUSrcB_ALUOp_PCSource_{instr_done,illegal_op}
  localparam logic [18:0] E_RESET   = 19'b0000_0000_000_00_00_00_00;
  localparam logic [18:0] E_FETCH_W = 19'b0000_1000_000_01_00_00_00;
  localparam logic [18:0] E_FETCH_R = 19'b1000_1010_000_01_00_00_00;
  localparam logic [18:0] E_DEC     = 19'b0000_0000_000_11_00_00_00;
  localparam logic [18:0] E_DEC_ILL = 19'b0000_0000_000_11_00_00_01;
  localparam logic [18:0] E_EXEC    = 19'b0000_0000_001_00_10_00_00;
  localparam logic [18:0] E_ALUWB   = 19'b0000_0000_110_00_00_00_10;
  localparam logic [18:0] E_BEQ     = 19'b0100_0000_001_00_01_01_10;
  localparam logic [18:0] E_BNE     = 19'b0110_0000_001_00_01_01_10;
  localparam logic [18:0] E_MEMADR  = 19'b0000_0000_001_10_00_00_00;
  localparam logic [18:0] E_MEMRD   = 19'b0001_1000_000_00_00_00_00;
  localparam logic [18:0] E_MEMWB   = 19'b0000_0001_010_00_00_00_10;
  localparam logic [18:0] E_MEMWR_W = 19'b0001_0100_000_00_00_00_00;
  localparam logic [18:0] E_MEMWR_R = 19'b0001_0100_000_00_00_00_10;
  localparam logic [18:0] E_ADDIEX  = 19'b0000_0000_001_10_00_00_00;
  localparam logic [18:0] E_ADDIWB  = 19'b0000_0000_010_00_00_00_10;

  typedef struct {
    int         id;
    logic [3:0] st;
    logic [18:0] sig;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   step_id   = 0;
  int   done_seen = 0;

  logic [18:0] act_sig;
  assign act_sig = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                    instr_done, illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every cycle the DUT presents a state/control word; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check($sformatf("step%0d {state,ctrl}", e.id), {9'd0, state_o, act_sig}, {9'd0, e.st, e.sig});
        if (instr_done) done_seen++;
      end
    end
  end

  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input state_t st, input logic [18:0] sig);
    rst_n     = rst;
    operation = op;
    mem_ready = mr;
    sb_q.push_back('{step_id, 4'(st), sig});
    step_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    operation = 6'($urandom);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three cycles with random inputs, then release.
    repeat (3) step(1'b0, 6'($urandom), 1'($urandom), S_RESET, E_RESET);
    step(1'b1, 6'd0, 1'b1, S_RESET, E_RESET);

    // R-format, memory ready: 4 cycles.
    step(1'b1, 6'd0, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd0, 1'b1, S_DECODE, E_DEC);
    step(1'b1, 6'd0, 1'b1, S_EXEC,   E_EXEC);
    step(1'b1, 6'd0, 1'b0, S_ALUWB,  E_ALUWB);

    // lw with one fetch wait and three read waits; opcode bus changes after DECODE.
    step(1'b1, 6'd35, 1'b0, S_FETCH,  E_FETCH_W);
    step(1'b1, 6'd35, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd35, 1'b0, S_DECODE, E_DEC);
    step(1'b1, 6'd43, 1'b1, S_MEMADR, E_MEMADR);
    step(1'b1, 6'd43, 1'b0, S_MEMRD,  E_MEMRD);
    step(1'b1, 6'd43, 1'b0, S_MEMRD,  E_MEMRD);
    step(1'b1, 6'd43, 1'b0, S_MEMRD,  E_MEMRD);
    step(1'b1, 6'd43, 1'b1, S_MEMRD,  E_MEMRD);
    step(1'b1, 6'd2,  1'b0, S_MEMWB,  E_MEMWB);

    // bne then beq, 3 cycles each; opcode bus flips during BRANCH.
    step(1'b1, 6'd5, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd5, 1'b1, S_DECODE, E_DEC);
    step(1'b1, 6'd4, 1'b1, S_BRANCH, E_BNE);
    step(1'b1, 6'd4, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd4, 1'b1, S_DECODE, E_DEC);
    step(1'b1, 6'd5, 1'b1, S_BRANCH, E_BEQ);

    // Illegal opcode 2 returns to FETCH with no write strobes.
    step(1'b1, 6'd0, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd2, 1'b1, S_DECODE, E_DEC_ILL);

    // addi, 4 cycles.
    step(1'b1, 6'd8, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd8, 1'b1, S_DECODE, E_DEC);
    step(1'b1, 6'd8, 1'b1, S_ADDIEX, E_ADDIEX);
    step(1'b1, 6'd8, 1'b1, S_ADDIWB, E_ADDIWB);

    // sw with one write wait.
    step(1'b1, 6'd43, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd43, 1'b1, S_DECODE, E_DEC);
    step(1'b1, 6'd35, 1'b1, S_MEMADR, E_MEMADR);
    step(1'b1, 6'd35, 1'b0, S_MEMWR,  E_MEMWR_W);
    step(1'b1, 6'd35, 1'b1, S_MEMWR,  E_MEMWR_R);

    // sw aborted by reset while waiting in MEMWR.
    step(1'b1, 6'd43, 1'b1, S_FETCH,  E_FETCH_R);
    step(1'b1, 6'd43, 1'b1, S_DECODE, E_DEC);
    step(1'b1, 6'd43, 1'b0, S_MEMADR, E_MEMADR);
    step(1'b1, 6'd43, 1'b0, S_MEMWR,  E_MEMWR_W);
    step(1'b0, 6'd43, 1'b0, S_RESET,  E_RESET);
    step(1'b0, 6'd43, 1'b1, S_RESET,  E_RESET);
    step(1'b1, 6'd0,  1'b1, S_RESET,  E_RESET);
    step(1'b1, 6'd0,  1'b1, S_FETCH,  E_FETCH_R);

    @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    // R, lw, bne, beq, addi, sw complete; the illegal op and aborted sw do not.
    check("instr_done pulses", 32'(done_seen), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
